// File: rtl/dmem_pkg.sv
// dmem_pkg: access-mode constants, FSM states and mode legality shared by the data-memory responder
package dmem_pkg;
  localparam logic [2:0] MODE_B  = 3'b000;
  localparam logic [2:0] MODE_H  = 3'b001;
  localparam logic [2:0] MODE_W  = 3'b010;
  localparam logic [2:0] MODE_BU = 3'b100;
  localparam logic [2:0] MODE_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  function automatic logic mode_is_legal(input logic [2:0] mode, input logic we);
    return (mode inside {MODE_B, MODE_H, MODE_W}) || (!we && (mode inside {MODE_BU, MODE_HU}));
  endfunction
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: store byte-lane merge and little-endian load extract/extend
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [2:0]  mode,
  input  logic [1:0]  lane,
  output logic [31:0] new_word,
  output logic [31:0] rdata
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = old_word[{lane, 3'b000} +: 8];
    h = lane[1] ? old_word[31:16] : old_word[15:0];
    new_word = old_word;
    if (mode[1:0] == 2'b00) new_word[{lane, 3'b000} +: 8] = wdata[7:0];
    else if (mode[1:0] == 2'b01) new_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
    else new_word = wdata;
    rdata = (mode == MODE_B)  ? {{24{b[7]}}, b} :
            (mode == MODE_BU) ? {24'h0, b} :
            (mode == MODE_H)  ? {{16{h[15]}}, h} :
            (mode == MODE_HU) ? {16'h0, h} : old_word;
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding load/store responder with programmable wait states
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_mode,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;

  logic [31:0] mem [DEPTH_WORDS];
  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] ld_q, ld_d, rsp_rdata_q, rsp_rdata_d;
  logic        err_q, err_d, rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic        accept, err, misaligned;
  logic [AW-1:0] idx;
  logic [31:0] cur_word, new_word, ext_word;

  assign idx      = req_addr[AW+1:2];
  assign cur_word = mem[idx];
  // the response strobe is registered, so IDLE stays closed for the cycle it is visible
  assign req_ready = (state_q == IDLE) && !rsp_valid_q && !reset;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  dmem_lane_align u_align (
    .old_word (cur_word),
    .wdata    (req_wdata),
    .mode     (req_mode),
    .lane     (req_addr[1:0]),
    .new_word (new_word),
    .rdata    (ext_word)
  );

  always_comb begin
    misaligned = (req_mode[1:0] == 2'b01 && req_addr[0]) || (req_mode == MODE_W && req_addr[1:0] != 2'b00);
    err = misaligned || !mode_is_legal(req_mode, req_we) || (req_addr >= 32'(4 * DEPTH_WORDS));
    state_d = state_q;
    cnt_d = cnt_q;
    ld_d = ld_q;
    err_d = err_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d = rsp_err_q;
    if (accept) begin
      state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
      cnt_d = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;
      ld_d = (err || req_we) ? 32'h0 : ext_word;
      err_d = err;
    end else if (state_q == WAIT) begin
      state_d = (cnt_q == 3'd0) ? RESP : WAIT;
      cnt_d = (cnt_q == 3'd0) ? 3'd0 : cnt_q - 3'd1;
    end else if (state_q == RESP) begin
      state_d = IDLE;
      rsp_valid_d = 1'b1;
      rsp_rdata_d = ld_q;
      rsp_err_d = err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= 3'd0;
      ld_q <= 32'h0;
      err_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ld_q <= ld_d;
      err_q <= err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && req_we && !err) mem[idx] <= new_word;
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: table-driven, sequence and randomized checks against a byte-level memory model
module tb_dmem_responder;
  logic        clk = 0, reset = 1, req_valid = 0, req_we = 0;
  logic [2:0]  req_mode = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        rdy0, rv0, re0;
  logic [31:0] rd0;
  int pass_cnt = 0, total_cnt = 0;
  logic [7:0] ref_mem [4096];

  typedef struct {
    logic        we;
    logic [2:0]  mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        err;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_mode(req_mode), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy0),
    .req_we(req_we), .req_mode(req_mode), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(re0));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // byte-addressed view of the RAM: sizes, alignment and extension straight from the access rules
  task automatic model(input logic we, input logic [2:0] mode, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rd, output logic e);
    int sz;
    logic [31:0] v;
    logic legal;
    sz = (mode[1:0] == 2'b00) ? 1 : (mode[1:0] == 2'b01) ? 2 : 4;
    legal = (mode inside {3'd0, 3'd1, 3'd2}) || (!we && (mode inside {3'd4, 3'd5}));
    e = !legal || (addr % sz) != 0 || addr >= 32'd4096;
    rd = 0;
    if (!e && we) for (int i = 0; i < sz; i++) ref_mem[addr + i] = wdata[8*i +: 8];
    if (!e && !we) begin
      v = 0;
      for (int i = 0; i < sz; i++) v = v | (32'(ref_mem[addr + i]) << (8 * i));
      if (sz < 4 && !mode[2] && v[8*sz-1]) v = v | ~((32'd1 << (8 * sz)) - 1);
      rd = v;
    end
  endtask

  task automatic run(input string name, input logic we, input logic [2:0] mode, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_e);
    int n, lat;
    bit got;
    @(negedge clk);
    req_we = we; req_mode = mode; req_addr = addr; req_wdata = wdata; req_valid = 1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) begin
      req_valid = 0;
      chk({name, " ready timeout"}, 0, 1);
      return;
    end
    @(posedge clk); #1 req_valid = 0;
    lat = 0; got = 0;
    while (!got && lat < 50) begin @(posedge clk); lat++; @(negedge clk); got = rsp_valid; end
    if (!got) begin
      chk({name, " rsp timeout"}, 0, 1);
      return;
    end
    chk({name, " rdata"}, rsp_rdata, exp_rd);
    chk({name, " err"}, 32'(rsp_err), 32'(exp_e));
    chk({name, " latency"}, lat, 2);
    @(negedge clk);
    chk({name, " strobe width"}, 32'(rsp_valid), 0);
  endtask

  initial begin
    logic [31:0] erd, w;
    logic ee;
    int acc1[$], acc0[$], n;
    bit seen;
    repeat (3) @(negedge clk);
    chk("reset req_ready", 32'(req_ready), 0);
    chk("reset rsp_valid", 32'(rsp_valid), 0);
    chk("reset rsp_rdata", rsp_rdata, 0);
    chk("reset rsp_err", 32'(rsp_err), 0);
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("ready after reset", 32'(req_ready), 1);

    for (int a = 0; a < 64; a += 4) begin
      w = $urandom;
      model(1, 3'b010, a, w, erd, ee);
      run($sformatf("init sw %0h", a), 1, 3'b010, a, w, erd, ee);
    end

    tbl.push_back('{1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        0});
    tbl.push_back('{0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 0});
    tbl.push_back('{0, 3'b000, 32'h13,  32'h0,        32'hFFFFFFDE, 0});
    tbl.push_back('{0, 3'b100, 32'h13,  32'h0,        32'h000000DE, 0});
    tbl.push_back('{0, 3'b001, 32'h12,  32'h0,        32'hFFFFDEAD, 0});
    tbl.push_back('{0, 3'b101, 32'h10,  32'h0,        32'h0000BEEF, 0});
    tbl.push_back('{1, 3'b000, 32'h11,  32'hFFFFFF55, 32'h0,        0});
    tbl.push_back('{0, 3'b010, 32'h10,  32'h0,        32'hDEAD55EF, 0});
    tbl.push_back('{1, 3'b001, 32'h12,  32'h00001234, 32'h0,        0});
    tbl.push_back('{0, 3'b010, 32'h10,  32'h0,        32'h123455EF, 0});
    tbl.push_back('{0, 3'b010, 32'h12,  32'h0,        32'h0,        1});
    tbl.push_back('{0, 3'b010, 32'h10,  32'h0,        32'h123455EF, 0});
    tbl.push_back('{1, 3'b001, 32'h11,  32'h0000ABCD, 32'h0,        1});
    tbl.push_back('{0, 3'b010, 32'h10,  32'h0,        32'h123455EF, 0});
    tbl.push_back('{1, 3'b010, 32'h1000, 32'h11111111, 32'h0,       1});
    tbl.push_back('{0, 3'b010, 32'h10,  32'h0,        32'h123455EF, 0});
    tbl.push_back('{0, 3'b011, 32'h10,  32'h0,        32'h0,        1});
    tbl.push_back('{0, 3'b010, 32'h10,  32'h0,        32'h123455EF, 0});
    tbl.push_back('{1, 3'b100, 32'h10,  32'h000000AA, 32'h0,        1});
    tbl.push_back('{0, 3'b010, 32'hFFFFFFFC, 32'h0,   32'h0,        1});
    tbl.push_back('{1, 3'b010, 32'hFFC, 32'h01020384, 32'h0,        0});
    tbl.push_back('{0, 3'b000, 32'hFFC, 32'h0,        32'hFFFFFF84, 0});
    tbl.push_back('{0, 3'b101, 32'h3,   32'h0,        32'h0,        1});
    tbl.push_back('{0, 3'b010, 32'h10,  32'h0,        32'h123455EF, 0});
    foreach (tbl[i]) begin
      model(tbl[i].we, tbl[i].mode, tbl[i].addr, tbl[i].wdata, erd, ee);
      run($sformatf("vec%0d", i), tbl[i].we, tbl[i].mode, tbl[i].addr, tbl[i].wdata, tbl[i].rd, tbl[i].err);
    end

    repeat (4) @(negedge clk);
    req_we = 0; req_mode = 3'b010; req_addr = 32'h10; req_valid = 1;
    n = 0;
    while ((acc1.size() < 3 || acc0.size() < 3) && n < 60) begin
      if (req_ready && acc1.size() < 3) acc1.push_back(n);
      if (rdy0 && acc0.size() < 3) acc0.push_back(n);
      if (req_ready && rsp_valid) chk("ready during response", 1, 0);
      @(negedge clk); n++;
    end
    @(posedge clk); #1 req_valid = 0;
    if (acc1.size() == 3 && acc0.size() == 3) begin
      chk("w1 accept gap a", acc1[1] - acc1[0], 4);
      chk("w1 accept gap b", acc1[2] - acc1[1], 4);
      chk("w0 accept gap a", acc0[1] - acc0[0], 3);
      chk("w0 accept gap b", acc0[2] - acc0[1], 3);
    end else chk("held-valid accepts", acc1.size() + acc0.size(), 6);
    repeat (8) @(negedge clk);

    model(1, 3'b010, 32'h20, 32'hCAFEF00D, erd, ee);
    req_we = 1; req_mode = 3'b010; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_valid = 1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    chk("reset-test ready", 32'(req_ready), 1);
    @(posedge clk); #1 req_valid = 0; reset = 1;
    @(negedge clk);
    chk("ready low in reset", 32'(req_ready), 0);
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("post-reset rsp_valid", 32'(rsp_valid), 0);
    chk("post-reset rsp_rdata", rsp_rdata, 0);
    chk("post-reset rsp_err", 32'(rsp_err), 0);
    chk("post-reset req_ready", 32'(req_ready), 1);
    chk("post-reset w0 outputs", {rd0[30:0], rv0}, 0);
    chk("post-reset w0 err/ready", {re0, rdy0}, 2'b01);
    seen = 0;
    repeat (5) begin @(negedge clk); seen |= rsp_valid; end
    chk("no aborted response", 32'(seen), 0);
    run("lw after abort", 0, 3'b010, 32'h20, 32'h0, 32'hCAFEF00D, 0);

    for (int i = 0; i < 80; i++) begin
      logic we;
      logic [2:0] mode;
      logic [31:0] addr;
      int r;
      we = 1'($urandom_range(0, 1));
      mode = 3'($urandom_range(0, 7));
      r = $urandom_range(0, 9);
      addr = (r < 8) ? 32'($urandom_range(0, 63)) : (r == 8) ? 32'h1000 + 32'($urandom_range(0, 255))
           : 32'hFFFFFFFF - 32'($urandom_range(0, 7));
      w = $urandom;
      model(we, mode, addr, w, erd, ee);
      run($sformatf("rand%0d", i), we, mode, addr, w, erd, ee);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder at the far end of the core's load/store interface: accepts one request at a time under a valid/ready handshake.
- Decodes the 3-bit access mode, checks alignment and range, merges store byte lanes into a word-wide RAM, extracts and extends load data.
- Returns the result after a programmable number of wait states, for stall-capable core variants.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the RAM; byte range is 0 to 4*DEPTH_WORDS-1.
- WAIT_CYCLES, 1, extra cycles between accept and response; legal range 0..7.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept.
- req_we  in  1  1 = store, 0 = load.
- req_mode  in  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  32  load result; 0 for stores and errors.
- rsp_err  out  1  error flag, qualified by rsp_valid.

Behaviour:
- Reset values: state IDLE, req_ready 0 while reset is high, rsp_valid 0, rsp_rdata 0, rsp_err 0, wait counter 0. RAM contents are not reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready: latch we, mode, addr, and the error check result.
  - Go to WAIT if WAIT_CYCLES > 0, else go to RESP.
- WAIT:
  - req_ready = 0.
  - Counter loads WAIT_CYCLES-1 on entry and decrements each cycle; exit to RESP when it reaches 0.
- RESP:
  - rsp_valid = 1 for exactly one cycle, then return to IDLE.
  - req_ready stays 0 in RESP.
- Latency: handshake at edge N, rsp_valid high in cycle N+1+WAIT_CYCLES.
- Throughput: one request per WAIT_CYCLES+3 cycles when req_valid is held high.
- Errors set rsp_err = 1 and rsp_rdata = 0, and the RAM is not written:
  - Misaligned: H/HU with addr[0] != 0; W with addr[1:0] != 0.
  - Illegal mode: 011, 110, 111; or BU/HU with we = 1.
  - Out of range: addr >= 4*DEPTH_WORDS, compared on the full 32 bits.
- Store commit:
  - The RAM word is written at the accept edge.
  - Lane select: B writes the lane given by addr[1:0] with wdata[7:0]; H writes the lane pair given by addr[1] with wdata[15:0]; W writes the full word.
  - All other lanes are preserved.
- Load read:
  - The word is read at the accept edge.
  - Little-endian extraction: B/H sign-extend, BU/HU zero-extend.
  - rsp_rdata is held registered from RESP entry until the next RESP; rsp_err likewise.
- Reset mid-operation: the state machine aborts with no rsp_valid. A store already committed at its accept edge stays in the RAM.
- req_* inputs are ignored outside IDLE. Requests are only accepted, never retracted, once req_ready is high.

Decomposition:
- Package dmem_pkg holds:
  - mode constants MODE_B=000, MODE_H=001, MODE_W=010, MODE_BU=100, MODE_HU=101;
  - the state enum {IDLE, WAIT, RESP};
  - the function mode_is_legal(mode, we).
- One combinational sub-module, dmem_lane_align, contains the store lane merge (old word, wdata, mode, addr[1:0] -> new word) and the load extract/extend (word, mode, addr[1:0] -> rdata).

Test Plan (DEPTH_WORDS=1024, WAIT_CYCLES=1):
- SW 0x10 = 0xDEADBEEF, then LW 0x10 -> rsp_rdata 0xDEADBEEF, rsp_err 0, rsp_valid exactly 2 cycles after each handshake edge, one cycle wide.
- Following that, load extends: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
- SB 0x11 with wdata 0xFFFFFF55, then LW 0x10 -> 0xDEAD55EF. SH 0x12 with 0x00001234, then LW 0x10 -> 0x123455EF.
- Error cases, each followed by LW 0x10 still returning 0x123455EF:
  - LW 0x12 -> rsp_err 1, rdata 0;
  - SH 0x11 -> rsp_err 1, no write;
  - SW 0x1000 -> rsp_err 1;
  - mode 011 -> rsp_err 1.
- req_valid held high for 3 loads -> accepts 4 cycles apart, req_ready low in WAIT and RESP. Repeat with WAIT_CYCLES=0 -> accepts 3 cycles apart.
- Reset asserted in the WAIT cycle of an SW 0x20 = 0xCAFEF00D -> no rsp_valid, all outputs 0, req_ready 1 the cycle after reset drops; LW 0x20 -> 0xCAFEF00D.
